// File: rtl/pwm_cap_pkg.sv
// Shared defaults and capture data types for the multi-channel PWM duty capture block.
package pwm_cap_pkg;

    localparam int PWM_CAP_WIDTH_DEF = 11;
    localparam int PWM_CAP_NCH_DEF   = 4;

    typedef logic        [PWM_CAP_WIDTH_DEF-1:0] duty_t;
    typedef logic signed [PWM_CAP_WIDTH_DEF:0]   diff_t;

endpackage

// File: rtl/pwm_cap_chan.sv
// One PWM channel: input synchronizer, high-time counter and latched duty value.
module pwm_cap_chan
    import pwm_cap_pkg::*;
#(
    parameter int WIDTH = PWM_CAP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             pwm_i,
    input  logic             term_i,
    output logic [WIDTH-1:0] hi_cnt_o,
    output logic [WIDTH-1:0] duty_o
);

    logic [1:0]       sync_q;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] duty_q;

    // The terminal cycle restarts the count and is itself never counted.
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (!en_i || term_i) begin
            hi_cnt_d = '0;
        end else if (sync_q[1]) begin
            hi_cnt_d = hi_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hi_cnt_q <= '0;
            duty_q   <= '0;
        end else begin
            sync_q   <= {sync_q[0], pwm_i};
            hi_cnt_q <= hi_cnt_d;
            if (term_i) begin
                duty_q <= hi_cnt_q;
            end
        end
    end

    assign hi_cnt_o = hi_cnt_q;
    assign duty_o   = duty_q;

endmodule

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM duty capture with per-pair differences and a valid/ready/overrun handshake.
module pwm_capture_mc
    import pwm_cap_pkg::*;
#(
    parameter int WIDTH = PWM_CAP_WIDTH_DEF,
    parameter int NCH   = PWM_CAP_NCH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [NCH-1:0]                 pwm_in,
    output logic [NCH*WIDTH-1:0]           duty_out,
    output logic [(NCH/2)*(WIDTH+1)-1:0]   diff_out,
    output logic                           vld,
    input  logic                           rdy,
    output logic                           ovr,
    input  logic                           clr_ovr
);

    localparam int                 DW      = WIDTH + 1;
    localparam logic [WIDTH-1:0]   PER_MAX = '1;

    if (NCH % 2 != 0) begin : g_nch_check
        $error("pwm_capture_mc: NCH must be even");
    end

    logic [WIDTH-1:0]           per_cnt_q, per_cnt_d;
    logic [(NCH/2)*DW-1:0]      diff_q, diff_d;
    logic                       vld_q, vld_d;
    logic                       ovr_q, ovr_d;
    logic                       term;
    logic [WIDTH-1:0]           hi_cnt [NCH];

    assign term      = en && (per_cnt_q == PER_MAX);
    assign per_cnt_d = en ? per_cnt_q + WIDTH'(1) : '0;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        pwm_cap_chan #(.WIDTH(WIDTH)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en),
            .pwm_i    (pwm_in[k]),
            .term_i   (term),
            .hi_cnt_o (hi_cnt[k]),
            .duty_o   (duty_out[k*WIDTH +: WIDTH])
        );
    end

    // Zero-extended subtraction in WIDTH+1 bits is exact, since |a-b| < 2^WIDTH.
    always_comb begin
        diff_d = diff_q;
        for (int j = 0; j < NCH/2; j++) begin
            diff_d[j*DW +: DW] = {1'b0, hi_cnt[2*j]} - {1'b0, hi_cnt[2*j+1]};
        end
    end

    // A capture always wins over a handshake; an overrun always wins over a clear.
    always_comb begin
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (term) begin
            vld_d = 1'b1;
        end else if (vld_q && rdy) begin
            vld_d = 1'b0;
        end
        if (term && vld_q && !rdy) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            diff_q    <= '0;
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            vld_q     <= vld_d;
            ovr_q     <= ovr_d;
            if (term) begin
                diff_q <= diff_d;
            end
        end
    end

    assign diff_out = diff_q;
    assign vld      = vld_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_pwm_capture_mc.sv
// Directed-plus-random bench for pwm_capture_mc against a cycle-count reference model.
module tb_pwm_capture_mc;

    localparam int WIDTH  = 11;
    localparam int NCH    = 4;
    localparam int DW     = WIDTH + 1;
    localparam int PERIOD = 1 << WIDTH;

    logic                     clk = 1'b0;
    logic                     rstN = 1'b0;
    logic                     enable = 1'b0;
    logic                     rdyIn = 1'b0;
    logic                     clrOvr = 1'b0;
    logic [NCH-1:0]           pwmIn = '0;
    logic [NCH*WIDTH-1:0]     dutyOut;
    logic [(NCH/2)*DW-1:0]    diffOut;
    logic                     vldOut;
    logic                     ovrOut;

    int testCount = 0;
    int failCount = 0;
    int phaseTb   = 0;
    int hiLen [NCH];

    int             mPhase;
    int             mCnt    [NCH];
    logic [NCH-1:0] mD1, mD2;
    logic [WIDTH-1:0] expDuty [NCH];
    logic [DW-1:0]  expDiff [NCH/2];
    logic           expVld, expOvr;
    logic           modelCapture;

    always #5 clk = ~clk;

    pwm_capture_mc #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .en       (enable),
        .pwm_in   (pwmIn),
        .duty_out (dutyOut),
        .diff_out (diffOut),
        .vld      (vldOut),
        .rdy      (rdyIn),
        .ovr      (ovrOut),
        .clr_ovr  (clrOvr)
    );

    // Reference: count input-high cycles (seen two clocks late) over phases 0..PERIOD-2 of each enabled period.
    assign modelCapture = enable && (mPhase == PERIOD - 1);

    always @(posedge clk or negedge rstN) begin : refModel
        if (!rstN) begin
            mPhase <= 0;
            mD1    <= '0;
            mD2    <= '0;
            expVld <= 1'b0;
            expOvr <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                mCnt[c]    <= 0;
                expDuty[c] <= '0;
            end
            for (int j = 0; j < NCH/2; j++) expDiff[j] <= '0;
        end else begin
            mD1 <= pwmIn;
            mD2 <= mD1;
            if (!enable) begin
                mPhase <= 0;
                for (int c = 0; c < NCH; c++) mCnt[c] <= 0;
            end else if (modelCapture) begin
                mPhase <= 0;
                for (int c = 0; c < NCH; c++) begin
                    mCnt[c]    <= 0;
                    expDuty[c] <= WIDTH'(mCnt[c]);
                end
                for (int j = 0; j < NCH/2; j++) expDiff[j] <= DW'(mCnt[2*j] - mCnt[2*j+1]);
            end else begin
                mPhase <= mPhase + 1;
                for (int c = 0; c < NCH; c++) mCnt[c] <= mCnt[c] + int'(mD2[c]);
            end
            if (modelCapture) expVld <= 1'b1;
            else if (expVld && rdyIn) expVld <= 1'b0;
            if (modelCapture && expVld && !rdyIn) expOvr <= 1'b1;
            else if (clrOvr) expOvr <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int c = 0; c < NCH; c++)
            checkValue($sformatf("%s duty%0d", tag, c), 32'(dutyOut[c*WIDTH +: WIDTH]), 32'(expDuty[c]));
        for (int j = 0; j < NCH/2; j++)
            checkValue($sformatf("%s diff%0d", tag, j), 32'(diffOut[j*DW +: DW]), 32'(expDiff[j]));
        checkValue($sformatf("%s vld", tag), 32'(vldOut), 32'(expVld));
        checkValue($sformatf("%s ovr", tag), 32'(ovrOut), 32'(expOvr));
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] pwm, input logic e, input logic r, input logic cl);
        pwmIn  = pwm;
        enable = e;
        rdyIn  = r;
        clrOvr = cl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic pickBit(input int mode);
        if (mode == 2) return ($urandom_range(0, 1500) == 0);
        return (mode != 0);
    endfunction

    // hiLen < 0 means a random level every cycle; otherwise high for phases [0, hiLen).
    task automatic runCycles(input int n, input int rdyMode, input int clrMode);
        logic [NCH-1:0] p;
        int consumed;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++)
                p[c] = (hiLen[c] < 0) ? 1'($urandom_range(0, 1)) : (phaseTb < hiLen[c]);
            consumed = phaseTb;
            applyStimulus(p, 1'b1, pickBit(rdyMode), pickBit(clrMode));
            phaseTb = (phaseTb + 1) % PERIOD;
            if (consumed == PERIOD - 1) checkOutput("capture");
        end
    endtask

    initial begin
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset");
        checkValue("reset duty bus", 32'(dutyOut[31:0]), 32'd0);
        checkValue("reset vld", 32'(vldOut), 32'd0);

        rstN     = 1'b1;
        phaseTb  = 0;
        hiLen[0] = 512;
        hiLen[1] = PERIOD;
        hiLen[2] = 0;
        hiLen[3] = -1;
        runCycles(2 * PERIOD, 1, 0);
        checkValue("duty ch0 512", 32'(dutyOut[0 +: WIDTH]), 32'd512);
        checkValue("duty ch1 full", 32'(dutyOut[WIDTH +: WIDTH]), 32'd2047);
        checkValue("duty ch2 zero", 32'(dutyOut[2*WIDTH +: WIDTH]), 32'd0);
        checkValue("vld after capture", 32'(vldOut), 32'd1);
        runCycles(1, 1, 0);
        checkValue("vld one-cycle pulse", 32'(vldOut), 32'd0);
        runCycles(PERIOD - phaseTb, 1, 0);

        hiLen[0] = 1536;
        hiLen[1] = 512;
        runCycles(2 * PERIOD, 1, 0);
        checkValue("diff pair0 +1024", 32'(diffOut[0 +: DW]), 32'h400);
        hiLen[0] = 512;
        hiLen[1] = 1536;
        runCycles(PERIOD, 1, 0);
        checkValue("diff pair0 -1024", 32'(diffOut[0 +: DW]), 32'hC00);

        runCycles(1, 1, 0);
        for (int c = 0; c < 3; c++) hiLen[c] = int'($urandom_range(0, PERIOD - 3));
        runCycles(PERIOD - 1, 0, 0);
        checkValue("first capture no ovr", 32'(ovrOut), 32'd0);
        for (int c = 0; c < 3; c++) hiLen[c] = int'($urandom_range(0, PERIOD - 3));
        runCycles(PERIOD, 0, 0);
        checkValue("overrun ovr", 32'(ovrOut), 32'd1);
        checkValue("overrun vld", 32'(vldOut), 32'd1);
        checkValue("overrun newest duty", 32'(dutyOut[0 +: WIDTH]), 32'(hiLen[0]));
        runCycles(1, 0, 1);
        checkValue("clr_ovr clears", 32'(ovrOut), 32'd0);
        checkOutput("after clr");

        runCycles(PERIOD - 1 - phaseTb, 0, 0);
        runCycles(1, 1, 0);
        checkValue("coincident vld", 32'(vldOut), 32'd1);
        checkValue("coincident ovr", 32'(ovrOut), 32'd0);
        runCycles(1, 1, 0);
        checkValue("handshake clears vld", 32'(vldOut), 32'd0);

        for (int c = 0; c < NCH; c++) hiLen[c] = -1;
        runCycles(PERIOD - phaseTb, 2, 2);
        runCycles(5 * PERIOD, 2, 2);

        hiLen[0] = 300;
        hiLen[1] = 1000;
        hiLen[2] = 1800;
        runCycles(1000, 1, 0);
        repeat (5) applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("disabled hold");
        phaseTb = 0;
        runCycles(PERIOD - 1, 1, 0);
        checkValue("no early capture after en", 32'(vldOut), 32'd0);
        runCycles(1, 1, 0);
        checkValue("capture after re-enable", 32'(vldOut), 32'd1);
        checkValue("re-enable duty ch0", 32'(dutyOut[0 +: WIDTH]), 32'd300);

        runCycles(700, 1, 0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset");
        checkValue("async reset duty bus", 32'(dutyOut[31:0]), 32'd0);
        checkValue("async reset diff bus", 32'(diffOut), 32'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        rstN    = 1'b1;
        phaseTb = 0;
        runCycles(PERIOD - 1, 1, 0);
        checkValue("post-reset no capture vld", 32'(vldOut), 32'd0);
        checkValue("post-reset no capture duty", 32'(dutyOut[0 +: WIDTH]), 32'd0);
        runCycles(1, 1, 0);
        checkValue("post-reset first capture vld", 32'(vldOut), 32'd1);
        checkValue("post-reset first capture duty", 32'(dutyOut[0 +: WIDTH]), 32'd300);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
